// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master round-robin Wishbone arbiter (wb_rr_arbiter).
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    function automatic int unsigned to_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned TO_W = to_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/wb_arb_timeout.sv
// Stalled-strobe watchdog: counts stb-without-ack cycles and pulses o_expire at the limit.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_expire
);

    localparam int unsigned    W     = to_w(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] r_cnt;

    // A same-cycle ack beats the timeout.
    assign o_expire = (r_cnt == LIMIT) && !i_ack;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear || i_ack || o_expire) begin
            r_cnt <= '0;
        end else if (i_stb && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave Wishbone arbiter, round-robin, grant held for the whole cyc.
// Optional stalled-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADR_W          = 32,
    parameter int unsigned DAT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic               m0_we_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic               m1_we_i,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    input  logic               s_ack_i,
    output logic [1:0]         grant_o
);

    arb_state_e r_state;
    logic [1:0] r_grant;
    logic       r_last;     // 1: m1 was granted last, so m0 wins the next tie
    logic       w_cyc;
    logic       w_stb;
    logic       w_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_grant <= GRANT_NONE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ARB_GNT0: begin
                    if (!m0_cyc_i) begin
                        r_last <= 1'b0;
                        if (m1_cyc_i) begin
                            r_state <= ARB_GNT1;
                            r_grant <= GRANT_M1;
                        end else begin
                            r_state <= ARB_IDLE;
                            r_grant <= GRANT_NONE;
                        end
                    end
                end
                ARB_GNT1: begin
                    if (!m1_cyc_i) begin
                        r_last <= 1'b1;
                        if (m0_cyc_i) begin
                            r_state <= ARB_GNT0;
                            r_grant <= GRANT_M0;
                        end else begin
                            r_state <= ARB_IDLE;
                            r_grant <= GRANT_NONE;
                        end
                    end
                end
                default: begin
                    if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                        r_state <= ARB_GNT0;
                        r_grant <= GRANT_M0;
                    end else if (m1_cyc_i) begin
                        r_state <= ARB_GNT1;
                        r_grant <= GRANT_M1;
                    end else begin
                        r_state <= ARB_IDLE;
                        r_grant <= GRANT_NONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_cyc    = 1'b0;
        w_stb    = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            ARB_GNT0: begin
                w_cyc    = m0_cyc_i;
                w_stb    = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = w_expire;
            end
            ARB_GNT1: begin
                w_cyc    = m1_cyc_i;
                w_stb    = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = w_expire;
            end
            default: ;
        endcase
    end

    assign s_cyc_o  = w_cyc;
    assign s_stb_o  = w_stb & ~w_expire;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = r_grant;

`ifdef WB_ARB_TIMEOUT_EN
    // Counter clears whenever the granted master is not in a cycle, i.e. on every grant change.
    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (clk),
        .i_reset (reset),
        .i_stb   (w_cyc & w_stb),
        .i_ack   (s_ack_i),
        .i_clear (~w_cyc),
        .o_expire(w_expire)
    );
`else
    localparam int unsigned unused_timeout_w = to_w(TIMEOUT_CYCLES);
    assign w_expire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: table of per-cycle vectors plus a read-data scoreboard and a watchdog sequence.
module tb_wb_rr_arbiter;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = DAT_W / 8;

    localparam logic [ADR_W-1:0] M0_ADR = 32'h0000_0010;
    localparam logic [ADR_W-1:0] M1_ADR = 32'h0000_0020;
    localparam logic [DAT_W-1:0] M0_WD  = 32'h1111_1111;
    localparam logic [DAT_W-1:0] M1_WD  = 32'h2222_2222;
    localparam logic [SEL_W-1:0] M0_SEL = 4'hF;
    localparam logic [SEL_W-1:0] M1_SEL = 4'h3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [ADR_W-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DAT_W-1:0] m0_dat_i, m0_dat_o, m1_dat_i, m1_dat_o, s_dat_o, s_dat_i;
    logic [SEL_W-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic             m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic             m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic             s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]       grant_o;

    wb_rr_arbiter #(
        .ADR_W         (ADR_W),
        .DAT_W         (DAT_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_adr_i(m0_adr_i),
        .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o),
        .m0_sel_i(m0_sel_i),
        .m0_we_i (m0_we_i),
        .m0_cyc_i(m0_cyc_i),
        .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i),
        .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o),
        .m1_sel_i(m1_sel_i),
        .m1_we_i (m1_we_i),
        .m1_cyc_i(m1_cyc_i),
        .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_ack_i (s_ack_i),
        .grant_o (grant_o)
    );

    typedef struct {
        logic             rst;
        logic             c0;
        logic             c1;
        logic             ack;
        logic [DAT_W-1:0] dat;
        logic [1:0]       g;
        logic             scyc;
        logic             a0;
        logic             a1;
        logic [ADR_W-1:0] adr;
    } vec_t;

    typedef struct {
        logic             m1;
        logic [DAT_W-1:0] dat;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(logic rst, logic c0, logic c1, logic ack, logic [DAT_W-1:0] dat,
                                logic [1:0] g, logic scyc, logic a0, logic a1,
                                logic [ADR_W-1:0] adr);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.c1 = c1; v.ack = ack; v.dat = dat;
        v.g = g; v.scyc = scyc; v.a0 = a0; v.a1 = a1; v.adr = adr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [DAT_W-1:0] act,
                       input logic [DAT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_and_check(input vec_t v, input int idx);
        sb_t e;
        logic [DAT_W-1:0] exp_wd;
        logic [SEL_W-1:0] exp_sel;
        reset    = v.rst;
        m0_cyc_i = v.c0;
        m0_stb_i = v.c0;
        m1_cyc_i = v.c1;
        m1_stb_i = v.c1;
        s_ack_i  = v.ack;
        s_dat_i  = v.dat;
        if (v.a0 || v.a1) begin
            e.m1  = v.a1;
            e.dat = v.dat;
            sb_q.push_back(e);
        end
        #1;
        exp_wd  = (v.g == 2'b01) ? M0_WD  : (v.g == 2'b10) ? M1_WD  : '0;
        exp_sel = (v.g == 2'b01) ? M0_SEL : (v.g == 2'b10) ? M1_SEL : '0;
        chk("grant_o", idx, 32'(grant_o), 32'(v.g));
        chk("s_cyc_o", idx, 32'(s_cyc_o), 32'(v.scyc));
        chk("s_stb_o", idx, 32'(s_stb_o), 32'(v.scyc));
        chk("s_we_o", idx, 32'(s_we_o), 32'(v.g == 2'b10));
        chk("s_adr_o", idx, s_adr_o, v.adr);
        chk("s_dat_o", idx, s_dat_o, exp_wd);
        chk("s_sel_o", idx, 32'(s_sel_o), 32'(exp_sel));
        chk("m0_ack_o", idx, 32'(m0_ack_o), 32'(v.a0));
        chk("m1_ack_o", idx, 32'(m1_ack_o), 32'(v.a1));
        chk("err_o", idx, 32'({m1_err_o, m0_err_o}), 32'd0);
        if (m0_ack_o || m1_ack_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", idx, 32'({m1_ack_o, m0_ack_o}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ack_master", idx, 32'({m1_ack_o, m0_ack_o}), e.m1 ? 32'd2 : 32'd1);
                chk("m0_dat_o", idx, m0_dat_o, e.dat);
                chk("m1_dat_o", idx, m1_dat_o, e.dat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int err_cnt;
        int err_at;
        int stb_in_err;
        int stb_last;

        reset    = 1'b1;
        m0_adr_i = M0_ADR; m0_dat_i = M0_WD; m0_sel_i = M0_SEL; m0_we_i = 1'b0;
        m1_adr_i = M1_ADR; m1_dat_i = M1_WD; m1_sel_i = M1_SEL; m1_we_i = 1'b1;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i  = 1'b0; s_dat_i = '0;

        // Single m0 read, ack two cycles after grant; reset folded into the last row.
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         2'b01, 1, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         2'b01, 1, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 1, 0, 1, 32'hCAFEF00D,  2'b01, 1, 1, 0, M0_ADR));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         2'b01, 0, 0, 0, M0_ADR));
        // Simultaneous request after reset: m0 first, then straight to m1.
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         2'b01, 1, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 1, 1, 1, 32'hA5A50001,  2'b01, 1, 1, 0, M0_ADR));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         2'b01, 0, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         2'b10, 1, 0, 0, M1_ADR));
        vecs.push_back(mk(0, 0, 1, 1, 32'h5A5A0002,  2'b10, 1, 0, 1, M1_ADR));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         2'b10, 0, 0, 0, M1_ADR));
        // Tie again with last=m1 -> m0; then tie with last=m0 -> m1.
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h33330003,  2'b01, 1, 1, 0, M0_ADR));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         2'b01, 0, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h44440004,  2'b10, 1, 0, 1, M1_ADR));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         2'b10, 0, 0, 0, M1_ADR));
        // m1 three-write burst while m0 waits, then handover to m0.
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h55550005,  2'b10, 1, 0, 1, M1_ADR));
        vecs.push_back(mk(0, 1, 1, 1, 32'h66660006,  2'b10, 1, 0, 1, M1_ADR));
        vecs.push_back(mk(0, 1, 1, 1, 32'h77770007,  2'b10, 1, 0, 1, M1_ADR));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         2'b10, 0, 0, 0, M1_ADR));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         2'b01, 1, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 1, 0, 1, 32'h88880008,  2'b01, 1, 1, 0, M0_ADR));
        // Reset while granted with stb pending; a late slave ack must not reach m0.
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         2'b01, 1, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 1, 0, 1, 32'h99990009,  2'b00, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         2'b01, 0, 0, 0, M0_ADR));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0));

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) apply_and_check(vecs[i], i);
        chk("scoreboard_empty", 900, 32'(sb_q.size()), 32'd0);

        // Hung slave on an m1 write: watchdog behaviour depends on the build.
        reset = 1'b1; s_ack_i = 1'b0; s_dat_i = '0;
        step();
        reset = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        err_cnt = 0; err_at = -1; stb_in_err = 0; stb_last = 0;
        for (int i = 0; i < 13; i++) begin
            #1;
            if (m1_err_o) begin
                err_cnt++;
                if (err_at < 0) err_at = i;
                if (s_stb_o) stb_in_err++;
            end
            if (m0_err_o || m0_ack_o || m1_ack_o) begin
                chk("hang_spurious", 1000 + i, 32'({m0_err_o, m0_ack_o, m1_ack_o}), 32'd0);
            end
            stb_last = int'(s_stb_o);
            @(posedge clk);
            #1;
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("err_pulses", 1100, 32'(err_cnt), 32'd1);
        chk("err_cycle", 1101, 32'(err_at), 32'd9);
        chk("stb_during_err", 1102, 32'(stb_in_err), 32'd0);
`else
        chk("err_pulses", 1100, 32'(err_cnt), 32'd0);
        chk("stb_held", 1101, 32'(stb_last), 32'd1);
`endif
        chk("grant_kept", 1103, 32'(grant_o), 32'd2);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        chk("grant_released", 1104, 32'(grant_o), 32'd0);
        chk("cyc_released", 1105, 32'(s_cyc_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
